// File: rtl/arm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arm_ctrl_pkg
// Brief   : Shared types and encodings for the multicycle ARM-subset control.
// Rev     : 1.0 - initial release
// ============================================================================
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] C_ALU_ADD = 2'b00;
  localparam logic [1:0] C_ALU_SUB = 2'b01;
  localparam logic [1:0] C_ALU_XOR = 2'b10;
  localparam logic [1:0] C_ALU_ROR = 2'b11;

  localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
  localparam logic [1:0] C_RES_DATA      = 2'b01;
  localparam logic [1:0] C_RES_ALURESULT = 2'b10;

  localparam logic [1:0] C_SRCB_RD2    = 2'b00;
  localparam logic [1:0] C_SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] C_SRCB_FOUR   = 2'b10;

  localparam logic [1:0] C_OP_DP  = 2'b00;
  localparam logic [1:0] C_OP_MEM = 2'b01;
  localparam logic [1:0] C_OP_BR  = 2'b10;
  localparam logic [1:0] C_OP_ILL = 2'b11;

  localparam logic [3:0] C_COND_EQ = 4'b0000;
  localparam logic [3:0] C_COND_NE = 4'b0001;
  localparam logic [3:0] C_COND_CS = 4'b0010;
  localparam logic [3:0] C_COND_CC = 4'b0011;
  localparam logic [3:0] C_COND_MI = 4'b0100;
  localparam logic [3:0] C_COND_PL = 4'b0101;
  localparam logic [3:0] C_COND_VS = 4'b0110;
  localparam logic [3:0] C_COND_VC = 4'b0111;
  localparam logic [3:0] C_COND_HI = 4'b1000;
  localparam logic [3:0] C_COND_LS = 4'b1001;
  localparam logic [3:0] C_COND_GE = 4'b1010;
  localparam logic [3:0] C_COND_LT = 4'b1011;
  localparam logic [3:0] C_COND_GT = 4'b1100;
  localparam logic [3:0] C_COND_LE = 4'b1101;
  localparam logic [3:0] C_COND_AL = 4'b1110;

  // nzcv is ordered {N, Z, C, V}; the 1111 code never executes
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      C_COND_EQ: cond_holds = z;
      C_COND_NE: cond_holds = ~z;
      C_COND_CS: cond_holds = c;
      C_COND_CC: cond_holds = ~c;
      C_COND_MI: cond_holds = n;
      C_COND_PL: cond_holds = ~n;
      C_COND_VS: cond_holds = v;
      C_COND_VC: cond_holds = ~v;
      C_COND_HI: cond_holds = c & ~z;
      C_COND_LS: cond_holds = ~c | z;
      C_COND_GE: cond_holds = (n == v);
      C_COND_LT: cond_holds = (n != v);
      C_COND_GT: cond_holds = ~z & (n == v);
      C_COND_LE: cond_holds = z | (n != v);
      C_COND_AL: cond_holds = 1'b1;
      default:   cond_holds = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module  : cond_unit
// Brief   : NZCV flag register, condition evaluation and flag-write gating.
// Rev     : 1.0 - initial release
// ============================================================================
module cond_unit
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic [1:0] i_flag_w,
  output logic       o_cond_ex
);

  logic [3:0] r_flags;
  logic [1:0] w_flag_wr;

  assign o_cond_ex = cond_holds(i_cond, r_flags);

  // A failed condition also suppresses the flag update
  assign w_flag_wr = i_flag_w & {2{o_cond_ex}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= FLAG_INIT;
    end else begin
      if (w_flag_wr[1]) r_flags[3:2] <= i_alu_flags[3:2];
      if (w_flag_wr[0]) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : Multicycle ARM-subset control FSM, ALU decode and strobe gating.
//           Optional MEM_READY_EN adds a mem_ready handshake on memory states.
// Rev     : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
`ifdef MEM_READY_EN
  input  logic       mem_ready,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_mem_rdy;
  logic       w_irw;
  logic       w_next_pc;
  logic       w_branch;
  logic       w_regw;
  logic       w_memw;
  logic       w_alu_op;
  logic [1:0] w_alu_ctrl;
  logic [1:0] w_flag_w;
  logic       w_cond_ex;
  logic       w_pcs;

`ifdef MEM_READY_EN
  assign w_mem_rdy = mem_ready;
`else
  assign w_mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH:    if (w_mem_rdy) w_next_state = DECODE;
      DECODE: begin
        case (Op)
          C_OP_MEM: w_next_state = MEMADR;
          C_OP_DP:  w_next_state = Funct[5] ? EXECUTEI : EXECUTER;
          C_OP_BR:  w_next_state = BRANCH;
          default:  w_next_state = FETCH;
        endcase
      end
      MEMADR:   w_next_state = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  if (w_mem_rdy) w_next_state = MEMWB;
      MEMWRITE: if (w_mem_rdy) w_next_state = FETCH;
      EXECUTER: w_next_state = ALUWB;
      EXECUTEI: w_next_state = ALUWB;
      default:  w_next_state = FETCH;
    endcase
  end

  always_comb begin
    w_irw     = 1'b0;
    w_next_pc = 1'b0;
    w_branch  = 1'b0;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_alu_op  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = C_SRCB_RD2;
    ResultSrc = C_RES_ALUOUT;
    illegal   = 1'b0;
    case (r_state)
      FETCH: begin
        w_irw     = w_mem_rdy;
        w_next_pc = w_mem_rdy;
        ALUSrcA   = 1'b1;
        ALUSrcB   = C_SRCB_FOUR;
        ResultSrc = C_RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = C_SRCB_FOUR;
        ResultSrc = C_RES_ALURESULT;
        illegal   = (Op == C_OP_ILL);
      end
      MEMADR:   ALUSrcB = C_SRCB_EXTIMM;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = C_RES_DATA;
        w_regw    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        w_memw = w_mem_rdy;
      end
      EXECUTER: w_alu_op = 1'b1;
      EXECUTEI: begin
        ALUSrcB  = C_SRCB_EXTIMM;
        w_alu_op = 1'b1;
      end
      ALUWB:    w_regw = 1'b1;
      BRANCH: begin
        ALUSrcB   = C_SRCB_EXTIMM;
        ResultSrc = C_RES_ALURESULT;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Flag writes only arise while ALUOp is high, i.e. in the execute states
  always_comb begin
    w_alu_ctrl = C_ALU_ADD;
    w_flag_w   = 2'b00;
    if (w_alu_op) begin
      case (Funct[4:1])
        4'b1000: w_alu_ctrl = C_ALU_ADD;
        4'b1001: w_alu_ctrl = C_ALU_SUB;
        4'b0010: w_alu_ctrl = C_ALU_XOR;
        4'b1110: w_alu_ctrl = C_ALU_ROR;
        default: w_alu_ctrl = C_ALU_ADD;
      endcase
      w_flag_w[1] = Funct[0];
      w_flag_w[0] = Funct[0] & ((w_alu_ctrl == C_ALU_ADD) || (w_alu_ctrl == C_ALU_SUB));
    end
  end

  cond_unit #(
    .FLAG_INIT (FLAG_INIT)
  ) u_cond_unit (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cond      (Cond),
    .i_alu_flags (ALUFlags),
    .i_flag_w    (w_flag_w),
    .o_cond_ex   (w_cond_ex)
  );

  assign ALUControl = w_alu_ctrl;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == C_OP_MEM) & ~Funct[0], (Op == C_OP_BR)};
  assign w_pcs      = w_branch | (w_regw & (Rd == 4'b1111));

  // Strobes are forced low while reset is held, even though state reads FETCH
  assign IRWrite  = w_irw & rst_n;
  assign RegWrite = w_regw & w_cond_ex & rst_n;
  assign MemWrite = w_memw & w_cond_ex & rst_n;
  assign PCWrite  = (w_next_pc | (w_pcs & w_cond_ex)) & rst_n;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_ctrl
// Brief   : Scoreboard bench for multicycle_ctrl; expected control vectors are
//           queued per cycle by the driver and checked by a negedge monitor.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
`ifdef MEM_READY_EN
  logic       mem_ready;
`endif
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  typedef struct {
    logic [16:0] v;
    string       nm;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [16:0] act;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.FLAG_INIT(4'b0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
`ifdef MEM_READY_EN
    .mem_ready  (mem_ready),
`endif
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .illegal    (illegal)
  );

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegSrc, RegWrite, illegal};

  // Field order: pcw adr memw irw res srca srcb aluc imm regsrc regw illegal
  function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic memw,
                                     input logic irw, input logic [1:0] res, input logic srca,
                                     input logic [1:0] srcb, input logic [1:0] aluc,
                                     input logic [1:0] imm, input logic [1:0] rsrc,
                                     input logic regw, input logic ill);
    return {pcw, adr, memw, irw, res, srca, srcb, aluc, imm, rsrc, regw, ill};
  endfunction

  function automatic logic [16:0] f_fetch(input logic [1:0] imm, input logic [1:0] rsrc);
    return ev(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, imm, rsrc, 0, 0);
  endfunction

  function automatic logic [16:0] f_decode(input logic [1:0] imm, input logic [1:0] rsrc,
                                           input logic ill);
    return ev(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, imm, rsrc, 0, ill);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      checks = checks + 1;
      if (act !== mon_e.v) begin
        failures = failures + 1;
        $display("FAIL %s: got %05h expected %05h", mon_e.nm, act, mon_e.v);
      end
    end
  end

  task automatic set_in(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                        input logic [3:0] r, input logic [3:0] af);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
  endtask

  task automatic step(input logic [16:0] v, input string nm);
    exp_t e;
    e.v = v;
    e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_branch(input logic [3:0] c, input logic taken, input string nm);
    set_in(c, 2'b10, 6'b000000, 4'b0000, 4'b0000);
    step(f_fetch(2'b10, 2'b01), {nm, "_fetch"});
    step(f_decode(2'b10, 2'b01, 0), {nm, "_decode"});
    step(ev(taken, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 2'b10, 2'b01, 0, 0), {nm, "_branch"});
  endtask

  task automatic do_str(input logic [3:0] c, input logic memw, input string nm);
    set_in(c, 2'b01, 6'b011000, 4'b0011, 4'b0000);
    step(f_fetch(2'b01, 2'b10), {nm, "_fetch"});
    step(f_decode(2'b01, 2'b10, 0), {nm, "_decode"});
    step(ev(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b10, 0, 0), {nm, "_memadr"});
    step(ev(0, 1, memw, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 0), {nm, "_memwrite"});
  endtask

  // Register-operand DP: ALUControl in EXECUTER and the ALUWB PC/reg strobes
  task automatic do_dp_r(input logic [3:0] c, input logic [5:0] f, input logic [3:0] rd,
                         input logic [3:0] af, input logic [1:0] aluc, input logic pcw_wb,
                         input logic regw_wb, input string nm);
    set_in(c, 2'b00, f, rd, af);
    step(f_fetch(2'b00, 2'b00), {nm, "_fetch"});
    step(f_decode(2'b00, 2'b00, 0), {nm, "_decode"});
    step(ev(0, 0, 0, 0, 2'b00, 0, 2'b00, aluc, 2'b00, 2'b00, 0, 0), {nm, "_execr"});
    step(ev(pcw_wb, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, regw_wb, 0), {nm, "_aluwb"});
  endtask

  task automatic do_dp_i(input logic [5:0] f, input logic [3:0] af, input logic [1:0] aluc,
                         input string nm);
    set_in(4'b1110, 2'b00, f, 4'b0100, af);
    step(f_fetch(2'b00, 2'b00), {nm, "_fetch"});
    step(f_decode(2'b00, 2'b00, 0), {nm, "_decode"});
    step(ev(0, 0, 0, 0, 2'b00, 0, 2'b01, aluc, 2'b00, 2'b00, 0, 0), {nm, "_execi"});
    step(ev(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0), {nm, "_aluwb"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
`ifdef MEM_READY_EN
    mem_ready = 1'b1;
`endif
    set_in(4'b0000, 2'b00, 6'b000000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    // Held in reset: FETCH muxing but no write strobes
    step(ev(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0), "reset_hold");
    rst_n = 1'b1;

    // Flags start at 0000; ADD without S leaves them alone despite ALUFlags=1111
    do_dp_r(4'b1110, 6'b001000, 4'b0001, 4'b1111, 2'b00, 0, 1, "add_r1");
    do_branch(4'b0000, 0, "beq_z0");

    // SUBS sets flags to 0100 (Z)
    do_dp_i(6'b110011, 4'b0100, 2'b01, "subs");
    do_branch(4'b0000, 1, "beq_z1");
    do_branch(4'b0001, 0, "bne_z1");

    // LDR: FETCH DECODE MEMADR MEMREAD MEMWB
    set_in(4'b1110, 2'b01, 6'b011001, 4'b0010, 4'b0000);
    step(f_fetch(2'b01, 2'b00), "ldr_fetch");
    step(f_decode(2'b01, 2'b00, 0), "ldr_decode");
    step(ev(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0), "ldr_memadr");
    step(ev(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0), "ldr_memread");
    step(ev(0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0), "ldr_memwb");

    do_str(4'b0000, 1, "streq_z1");

    do_dp_r(4'b1110, 6'b000100, 4'b0101, 4'b1111, 2'b10, 0, 1, "xor");
    // RORS updates NZ only: flags 0100 -> 1000 (CV stay 0 despite ALUFlags CV=11)
    do_dp_i(6'b111101, 4'b1011, 2'b11, "rors");

    do_str(4'b0000, 0, "streq_z0");
    do_branch(4'b0100, 1, "bmi_n1");
    do_branch(4'b0110, 0, "bvs_v0");

    // Illegal opcode: two cycles, pulse in DECODE
    set_in(4'b1110, 2'b11, 6'b000000, 4'b0000, 4'b0000);
    step(f_fetch(2'b11, 2'b00), "ill_fetch");
    step(f_decode(2'b11, 2'b00, 1), "ill_decode");

    do_dp_r(4'b1110, 6'b001000, 4'b1111, 4'b0000, 2'b00, 1, 1, "add_pc_al");
    do_dp_r(4'b0000, 6'b001000, 4'b1111, 4'b0000, 2'b00, 0, 0, "add_pc_eq_fail");

    // Reset while in MEMREAD: immediate FETCH, flags back to 0000
    set_in(4'b1110, 2'b01, 6'b011001, 4'b0010, 4'b0000);
    step(f_fetch(2'b01, 2'b00), "ldr2_fetch");
    step(f_decode(2'b01, 2'b00, 0), "ldr2_decode");
    step(ev(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, 0, 0), "ldr2_memadr");
    rst_n = 1'b0;
    step(ev(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0), "rst_midinstr");
    rst_n = 1'b1;
    do_branch(4'b0100, 0, "bmi_after_rst");
    do_branch(4'b0101, 1, "bpl_after_rst");

`ifdef MEM_READY_EN
    set_in(4'b1110, 2'b00, 6'b001000, 4'b0001, 4'b0000);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      step(ev(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0), "mr_fetch_wait");
    mem_ready = 1'b1;
    step(f_fetch(2'b00, 2'b00), "mr_fetch_go");
    step(f_decode(2'b00, 2'b00, 0), "mr_decode");
    step(ev(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), "mr_execr");
    step(ev(0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0), "mr_aluwb");

    set_in(4'b1110, 2'b01, 6'b011000, 4'b0011, 4'b0000);
    step(f_fetch(2'b01, 2'b10), "mr_str_fetch");
    step(f_decode(2'b01, 2'b10, 0), "mr_str_decode");
    step(ev(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b10, 0, 0), "mr_str_memadr");
    mem_ready = 1'b0;
    step(ev(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 0), "mr_str_wait");
    mem_ready = 1'b1;
    step(ev(0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b10, 0, 0), "mr_str_go");
    step(f_fetch(2'b01, 2'b10), "mr_str_back");
`endif

    // Every queued expectation must have been consumed by the monitor
    @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
